core_mem_port_arbiter: RTL and testbench
========================================

// Module: core_mem_port_arbiter
// PURPOSE
//  Shares one memory request bus between the core's instruction-fetch and data-memory requesters.
//  Sits between core_pipeline and the memory/MMU subsystem.
//  Arbitrates requests and registers the winning request onto the bus.
//  Tracks the owner of every outstanding read in an in-order tag FIFO, and routes each read
//  response back to the requester that issued it.
// PARAMETERS
//  OUTSTANDING    4   max reads in flight (power of 2, 2..16); sizes the owner FIFO
//  PRIORITY_MODE  0   0 = round-robin, 1 = data requester always wins a conflict
// PORTS
//  iCLOCK         in   1   clock
//  iRESET_SYNC    in   1   synchronous reset, active-high
//  iINST_REQ      in   1   fetch request (always a read); fields held until accepted
//  oINST_LOCK     out  1   1 = fetch request not accepted this cycle
//  iINST_MMUMOD   in   2   MMU mode of fetch
//  iINST_PDT      in   32  page directory table base of fetch
//  iINST_ADDR     in   32  fetch address
//  oINST_VALID    out  1   fetch response strobe
//  oINST_DATA     out  64  fetch response data
//  iDATA_REQ      in   1   data request; fields held until accepted
//  oDATA_LOCK     out  1   1 = data request not accepted this cycle
//  iDATA_RW       in   1   0 = write, 1 = read
//  iDATA_ORDER    in   2   access size code
//  iDATA_MASK     in   4   byte mask
//  iDATA_MMUMOD   in   2   MMU mode
//  iDATA_PDT      in   32  page directory table base
//  iDATA_ADDR     in   32  address
//  iDATA_DATA     in   32  write data
//  oDATA_VALID    out  1   data read response strobe
//  oDATA_DATA     out  64  data read response
//  oMEM_REQ       out  1   bus request; held with all fields until accepted
//  iMEM_LOCK      in   1   1 = memory cannot take the request this cycle
//  oMEM_RW, oMEM_ORDER, oMEM_MASK, oMEM_MMUMOD, oMEM_PDT, oMEM_ADDR, oMEM_DATA
//                 out  1/2/4/2/32/32/32   registered request fields
//  iMEM_VALID     in   1   read response strobe; responses return in issue order
//  iMEM_DATA      in   64  read response data
//  oPROTOCOL_ERR  out  1   sticky: response received with no read outstanding
// BEHAVIOUR
//  Reset
//   - All outputs go to 0.
//   - Owner FIFO and read counter are cleared.
//   - RR pointer = LAST_INST, so data wins the first conflict.
//   - In-flight state is discarded when reset is asserted mid-operation.
//  Acceptance and locks
//   - A requester is accepted in the cycle where REQ=1 and LOCK=0.
//   - oX_LOCK = !grant_X, combinational; it is 1 whenever the requester is not granted, including when REQ=0.
//   - stage_free = !oMEM_REQ | !iMEM_LOCK.
//   - rd_ok = count < OUTSTANDING. count uses the value at the start of the cycle; a pop in the same cycle does not free a slot.
//   - A candidate is eligible when REQ & stage_free & (write | rd_ok). Fetch counts as a read.
//  Arbitration
//   - Exactly one grant per cycle.
//   - If only one candidate is eligible, it wins.
//   - If both are eligible: PRIORITY_MODE=1 grants data; otherwise grant the requester that was not last granted.
//   - The RR pointer updates only on a grant.
//  Request stage
//   - On a grant, the oMEM_* fields load at the next clock edge and oMEM_REQ=1.
//   - Fetch is issued as RW=1, ORDER=2'b10, MASK=4'hF, DATA=0.
//   - Without a new grant, oMEM_REQ is cleared after a clock where !iMEM_LOCK.
//   - While iMEM_LOCK=1 the stage holds all fields unchanged.
//   - Zero-bubble back-to-back issue: a new grant is allowed in the same cycle the stage is accepted.
//  Owner FIFO
//   - Every granted read pushes its owner tag (0 = inst, 1 = data) at the grant.
//   - iMEM_VALID pops the head.
//   - Push and pop in the same cycle leave count unchanged.
//   - count range is 0..OUTSTANDING. Pointers are log2(OUTSTANDING) bits and wrap.
//  Response path
//   - One-cycle registered latency: iMEM_VALID at cycle N drives oINST_VALID or oDATA_VALID at N+1, per the head tag.
//   - The matching DATA output carries iMEM_DATA. The other strobe stays 0.
//   - Response DATA outputs hold their last value when their VALID=0.
//  Error case
//   - iMEM_VALID with count=0 is dropped: no strobe, no pop.
//   - It sets oPROTOCOL_ERR, which clears only on reset.
//  Writes
//   - Writes never push a tag and expect no response.
// TESTING
//  1. Lone fetch, addr 0x100, iMEM_LOCK=0 -> oMEM_REQ=1, oMEM_ADDR=0x100, RW=1 next cycle; iMEM_VALID with data 0xA5 -> oINST_VALID, oINST_DATA=0xA5 one cycle later.
//  2. Both request every cycle, PRIORITY_MODE=0 -> grants D,I,D,I...; PRIORITY_MODE=1 -> data granted every cycle, oINST_LOCK stays 1.
//  3. iMEM_LOCK=1 for 5 cycles with a request staged -> oMEM_* stable, both LOCK outputs 1; lock drops -> next grant issued in the same cycle.
//  4. OUTSTANDING=4: 4 data reads, no responses -> 5th read locked while a data write still issues; one iMEM_VALID -> 5th read accepted the following cycle.
//  5. Issue reads I,D,D,I, then return 4 responses -> strobes land on inst,data,data,inst in that order; a 5th spurious iMEM_VALID sets oPROTOCOL_ERR.
//  6. Reset asserted with 3 reads outstanding and a request staged -> next cycle all outputs 0, count 0; a fresh fetch issues normally.

Source files
------------

// File: rtl/core_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// core_mem_port_arbiter
//
// Purpose:
//   Shares one memory request bus between the core's instruction-fetch and
//   data-memory requesters. It picks one requester per cycle, registers the
//   winning request onto the bus, and records the owner of every read in an
//   in-order tag FIFO. Each read response is routed back to the requester
//   that issued it, one cycle after it arrives.
//
// Handshake:
//   A requester raises iX_REQ and holds its fields. It is accepted in the
//   cycle where iX_REQ=1 and oX_LOCK=0. oX_LOCK is combinational and is 1
//   whenever that requester is not granted, including while iX_REQ=0. The
//   bus side uses the same rule: oMEM_REQ and its fields are held until a
//   cycle with iMEM_LOCK=0. Read responses arrive on iMEM_VALID in issue
//   order and carry no tag.
//
// Ports:
//   iCLOCK, iRESET_SYNC        clock, synchronous active-high reset
//   iINST_* / oINST_*          fetch request (always a read) and its response
//   iDATA_* / oDATA_*          data request (read or write) and its response
//   oMEM_* / iMEM_LOCK         registered bus request and memory back-pressure
//   iMEM_VALID / iMEM_DATA     in-order read responses from memory
//   oPROTOCOL_ERR              sticky flag: a response came with no read pending
//
// Parameters:
//   OUTSTANDING    maximum reads in flight (power of 2, 2..16)
//   PRIORITY_MODE  0 = round-robin, 1 = data requester wins every conflict
// -----------------------------------------------------------------------------
module core_mem_port_arbiter #(
  parameter int OUTSTANDING   = 4,
  parameter int PRIORITY_MODE = 0
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  // instruction fetch requester
  input  logic        iINST_REQ,
  output logic        oINST_LOCK,
  input  logic [1:0]  iINST_MMUMOD,
  input  logic [31:0] iINST_PDT,
  input  logic [31:0] iINST_ADDR,
  output logic        oINST_VALID,
  output logic [63:0] oINST_DATA,
  // data requester
  input  logic        iDATA_REQ,
  output logic        oDATA_LOCK,
  input  logic        iDATA_RW,
  input  logic [1:0]  iDATA_ORDER,
  input  logic [3:0]  iDATA_MASK,
  input  logic [1:0]  iDATA_MMUMOD,
  input  logic [31:0] iDATA_PDT,
  input  logic [31:0] iDATA_ADDR,
  input  logic [31:0] iDATA_DATA,
  output logic        oDATA_VALID,
  output logic [63:0] oDATA_DATA,
  // memory bus
  output logic        oMEM_REQ,
  input  logic        iMEM_LOCK,
  output logic        oMEM_RW,
  output logic [1:0]  oMEM_ORDER,
  output logic [3:0]  oMEM_MASK,
  output logic [1:0]  oMEM_MMUMOD,
  output logic [31:0] oMEM_PDT,
  output logic [31:0] oMEM_ADDR,
  output logic [31:0] oMEM_DATA,
  input  logic        iMEM_VALID,
  input  logic [63:0] iMEM_DATA,
  output logic        oPROTOCOL_ERR
);

  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(OUTSTANDING);

  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  // request stage
  logic        r_mem_req;
  logic        r_mem_rw;
  logic [1:0]  r_mem_order;
  logic [3:0]  r_mem_mask;
  logic [1:0]  r_mem_mmumod;
  logic [31:0] r_mem_pdt;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_data;

  // arbitration history: 1 = fetch was granted last
  logic        r_last_inst;

  // owner tag FIFO
  logic [OUTSTANDING-1:0] r_tag;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;

  // response path
  logic        r_inst_valid;
  logic [63:0] r_inst_data;
  logic        r_data_valid;
  logic [63:0] r_data_data;
  logic        r_protocol_err;

  logic w_stage_free;
  logic w_rd_ok;
  logic w_inst_elig;
  logic w_data_elig;
  logic w_grant_inst;
  logic w_grant_data;
  logic w_push;
  logic w_push_tag;
  logic w_pop;
  logic w_head_tag;
  logic w_rsp_orphan;

  // The stage can take a new request if it is empty or is being handed to
  // memory this cycle, which gives zero-bubble back-to-back issue.
  assign w_stage_free = !r_mem_req || !iMEM_LOCK;

  // Uses the count from the start of the cycle: a response popping in this
  // same cycle does not open a slot until the next one.
  assign w_rd_ok = (r_count < MAX_CNT);

  assign w_inst_elig = iINST_REQ && w_stage_free && w_rd_ok;
  assign w_data_elig = iDATA_REQ && w_stage_free && (!iDATA_RW || w_rd_ok);

  always_comb begin
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    if (w_inst_elig && w_data_elig) begin
      // conflict: fixed data priority, or hand the bus to whoever did not win last
      if ((PRIORITY_MODE != 0) || r_last_inst) begin
        w_grant_data = 1'b1;
      end else begin
        w_grant_inst = 1'b1;
      end
    end else begin
      w_grant_inst = w_inst_elig;
      w_grant_data = w_data_elig;
    end
  end

  assign oINST_LOCK = !w_grant_inst;
  assign oDATA_LOCK = !w_grant_data;

  // Reads push their owner at grant time; writes never expect a response.
  assign w_push       = w_grant_inst || (w_grant_data && iDATA_RW);
  assign w_push_tag   = w_grant_inst ? TAG_INST : TAG_DATA;
  assign w_pop        = iMEM_VALID && (r_count != '0);
  assign w_rsp_orphan = iMEM_VALID && (r_count == '0);
  assign w_head_tag   = r_tag[r_rd_ptr];

  // arbitration history
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_last_inst <= 1'b1;
    end else if (w_grant_inst) begin
      r_last_inst <= 1'b1;
    end else if (w_grant_data) begin
      r_last_inst <= 1'b0;
    end
  end

  // request stage: load on grant, retire on acceptance, hold while locked
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_mem_req    <= 1'b0;
      r_mem_rw     <= 1'b0;
      r_mem_order  <= 2'b00;
      r_mem_mask   <= 4'h0;
      r_mem_mmumod <= 2'b00;
      r_mem_pdt    <= 32'h0;
      r_mem_addr   <= 32'h0;
      r_mem_data   <= 32'h0;
    end else if (w_grant_inst) begin
      r_mem_req    <= 1'b1;
      r_mem_rw     <= 1'b1;
      r_mem_order  <= 2'b10;
      r_mem_mask   <= 4'hF;
      r_mem_mmumod <= iINST_MMUMOD;
      r_mem_pdt    <= iINST_PDT;
      r_mem_addr   <= iINST_ADDR;
      r_mem_data   <= 32'h0;
    end else if (w_grant_data) begin
      r_mem_req    <= 1'b1;
      r_mem_rw     <= iDATA_RW;
      r_mem_order  <= iDATA_ORDER;
      r_mem_mask   <= iDATA_MASK;
      r_mem_mmumod <= iDATA_MMUMOD;
      r_mem_pdt    <= iDATA_PDT;
      r_mem_addr   <= iDATA_ADDR;
      r_mem_data   <= iDATA_DATA;
    end else if (!iMEM_LOCK) begin
      r_mem_req    <= 1'b0;
    end
  end

  // owner tag FIFO; pointers wrap because OUTSTANDING is a power of two
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_tag    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_tag[r_wr_ptr] <= w_push_tag;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // response routing, one registered cycle; data outputs hold between strobes
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      r_inst_valid   <= 1'b0;
      r_inst_data    <= 64'h0;
      r_data_valid   <= 1'b0;
      r_data_data    <= 64'h0;
      r_protocol_err <= 1'b0;
    end else begin
      r_inst_valid <= w_pop && (w_head_tag == TAG_INST);
      r_data_valid <= w_pop && (w_head_tag == TAG_DATA);
      if (w_pop && (w_head_tag == TAG_INST)) begin
        r_inst_data <= iMEM_DATA;
      end
      if (w_pop && (w_head_tag == TAG_DATA)) begin
        r_data_data <= iMEM_DATA;
      end
      if (w_rsp_orphan) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  assign oMEM_REQ      = r_mem_req;
  assign oMEM_RW       = r_mem_rw;
  assign oMEM_ORDER    = r_mem_order;
  assign oMEM_MASK     = r_mem_mask;
  assign oMEM_MMUMOD   = r_mem_mmumod;
  assign oMEM_PDT      = r_mem_pdt;
  assign oMEM_ADDR     = r_mem_addr;
  assign oMEM_DATA     = r_mem_data;
  assign oINST_VALID   = r_inst_valid;
  assign oINST_DATA    = r_inst_data;
  assign oDATA_VALID   = r_data_valid;
  assign oDATA_DATA    = r_data_data;
  assign oPROTOCOL_ERR = r_protocol_err;

endmodule

// File: tb/tb_core_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_core_mem_port_arbiter
//
// Directed bench for core_mem_port_arbiter. dut0 is round-robin, dut1 uses
// fixed data priority and shares all inputs with dut0; only its lock outputs
// are checked. Expected bus requests and read responses are queued by the
// stimulus and consumed by two monitors on the falling edge.
// -----------------------------------------------------------------------------
module tb_core_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic        inst_req = 0;
  logic [1:0]  inst_mmumod = 0;
  logic [31:0] inst_pdt = 0;
  logic [31:0] inst_addr = 0;
  logic        data_req = 0;
  logic        data_rw = 0;
  logic [1:0]  data_order = 0;
  logic [3:0]  data_mask = 0;
  logic [1:0]  data_mmumod = 0;
  logic [31:0] data_pdt = 0;
  logic [31:0] data_addr = 0;
  logic [31:0] data_wdata = 0;
  logic        mem_lock = 0;
  logic        mem_valid = 0;
  logic [63:0] mem_rdata = 0;

  // ---------------- dut0 outputs ----------------
  logic        d0_inst_lock, d0_inst_valid, d0_data_lock, d0_data_valid;
  logic [63:0] d0_inst_data, d0_data_data;
  logic        d0_mem_req, d0_mem_rw, d0_err;
  logic [1:0]  d0_mem_order, d0_mem_mmumod;
  logic [3:0]  d0_mem_mask;
  logic [31:0] d0_mem_pdt, d0_mem_addr, d0_mem_data;

  // ---------------- dut1 outputs ----------------
  logic        d1_inst_lock, d1_inst_valid, d1_data_lock, d1_data_valid;
  logic [63:0] d1_inst_data, d1_data_data;
  logic        d1_mem_req, d1_mem_rw, d1_err;
  logic [1:0]  d1_mem_order, d1_mem_mmumod;
  logic [3:0]  d1_mem_mask;
  logic [31:0] d1_mem_pdt, d1_mem_addr, d1_mem_data;

  core_mem_port_arbiter #(.OUTSTANDING(4), .PRIORITY_MODE(0)) dut0 (
    .iCLOCK(clk), .iRESET_SYNC(rst),
    .iINST_REQ(inst_req), .oINST_LOCK(d0_inst_lock), .iINST_MMUMOD(inst_mmumod),
    .iINST_PDT(inst_pdt), .iINST_ADDR(inst_addr),
    .oINST_VALID(d0_inst_valid), .oINST_DATA(d0_inst_data),
    .iDATA_REQ(data_req), .oDATA_LOCK(d0_data_lock), .iDATA_RW(data_rw),
    .iDATA_ORDER(data_order), .iDATA_MASK(data_mask), .iDATA_MMUMOD(data_mmumod),
    .iDATA_PDT(data_pdt), .iDATA_ADDR(data_addr), .iDATA_DATA(data_wdata),
    .oDATA_VALID(d0_data_valid), .oDATA_DATA(d0_data_data),
    .oMEM_REQ(d0_mem_req), .iMEM_LOCK(mem_lock), .oMEM_RW(d0_mem_rw),
    .oMEM_ORDER(d0_mem_order), .oMEM_MASK(d0_mem_mask), .oMEM_MMUMOD(d0_mem_mmumod),
    .oMEM_PDT(d0_mem_pdt), .oMEM_ADDR(d0_mem_addr), .oMEM_DATA(d0_mem_data),
    .iMEM_VALID(mem_valid), .iMEM_DATA(mem_rdata), .oPROTOCOL_ERR(d0_err)
  );

  core_mem_port_arbiter #(.OUTSTANDING(4), .PRIORITY_MODE(1)) dut1 (
    .iCLOCK(clk), .iRESET_SYNC(rst),
    .iINST_REQ(inst_req), .oINST_LOCK(d1_inst_lock), .iINST_MMUMOD(inst_mmumod),
    .iINST_PDT(inst_pdt), .iINST_ADDR(inst_addr),
    .oINST_VALID(d1_inst_valid), .oINST_DATA(d1_inst_data),
    .iDATA_REQ(data_req), .oDATA_LOCK(d1_data_lock), .iDATA_RW(data_rw),
    .iDATA_ORDER(data_order), .iDATA_MASK(data_mask), .iDATA_MMUMOD(data_mmumod),
    .iDATA_PDT(data_pdt), .iDATA_ADDR(data_addr), .iDATA_DATA(data_wdata),
    .oDATA_VALID(d1_data_valid), .oDATA_DATA(d1_data_data),
    .oMEM_REQ(d1_mem_req), .iMEM_LOCK(mem_lock), .oMEM_RW(d1_mem_rw),
    .oMEM_ORDER(d1_mem_order), .oMEM_MASK(d1_mem_mask), .oMEM_MMUMOD(d1_mem_mmumod),
    .oMEM_PDT(d1_mem_pdt), .oMEM_ADDR(d1_mem_addr), .oMEM_DATA(d1_mem_data),
    .iMEM_VALID(mem_valid), .iMEM_DATA(mem_rdata), .oPROTOCOL_ERR(d1_err)
  );

  // ---------------- scoreboard ----------------
  // request entry: {rw, order, mask, mmumod, pdt, addr, data}
  logic [104:0] req_q[$];
  // response entry: {owner (0 = inst, 1 = data), data}
  logic [64:0]  exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req  = 1'b0;
    data_req  = 1'b0;
    mem_valid = 1'b0;
    mem_lock  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Called right after tick(): let the combinational locks settle, require a
  // fetch grant and queue the bus request it must produce.
  task automatic expect_grant_inst(input string name);
    #2;
    check(name, d0_inst_lock, 1'b0);
    req_q.push_back({1'b1, 2'b10, 4'hF, inst_mmumod, inst_pdt, inst_addr, 32'h0});
  endtask

  task automatic expect_grant_data(input string name);
    #2;
    check(name, d0_data_lock, 1'b0);
    req_q.push_back({data_rw, data_order, data_mask, data_mmumod, data_pdt, data_addr, data_wdata});
  endtask

  task automatic send_rsp(input logic owner, input logic [63:0] value);
    mem_valid = 1'b1;
    mem_rdata = value;
    exp_q.push_back({owner, value});
  endtask

  task automatic set_data(input logic rw, input logic [31:0] addr, input logic [31:0] wdata);
    data_req    = 1'b1;
    data_rw     = rw;
    data_order  = 2'b01;
    data_mask   = 4'h3;
    data_mmumod = 2'b11;
    data_pdt    = 32'h0000_3000;
    data_addr   = addr;
    data_wdata  = wdata;
  endtask

  task automatic set_inst(input logic [31:0] addr);
    inst_req    = 1'b1;
    inst_mmumod = 2'b01;
    inst_pdt    = 32'h0000_1000;
    inst_addr   = addr;
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && d0_mem_req && !mem_lock) begin
      if (req_q.size() == 0) begin
        check("req_unexpected", 1'b1, 1'b0);
      end else begin
        check("req_fields",
              {d0_mem_rw, d0_mem_order, d0_mem_mask, d0_mem_mmumod, d0_mem_pdt, d0_mem_addr, d0_mem_data},
              req_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst && (d0_inst_valid || d0_data_valid)) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {d0_data_valid, d0_inst_valid}, 2'b00);
      end else begin
        e = exp_q.pop_front();
        check("rsp_owner", {d0_data_valid, d0_inst_valid}, e[64] ? 2'b10 : 2'b01);
        check("rsp_data", e[64] ? d0_data_data : d0_inst_data, e[63:0]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [3:0] t5_owner;
    t5_owner = 4'b0110;  // bit k = owner of k-th read: I, D, D, I

    // reset state
    do_reset();
    #2;
    check("rst_mem_req", d0_mem_req, 1'b0);
    check("rst_mem_fields", {d0_mem_rw, d0_mem_order, d0_mem_mask, d0_mem_addr, d0_mem_data}, '0);
    check("rst_valids", {d0_inst_valid, d0_data_valid}, 2'b00);
    check("rst_rsp_data", {d0_inst_data, d0_data_data}, '0);
    check("rst_err", d0_err, 1'b0);
    check("idle_locks", {d0_inst_lock, d0_data_lock}, 2'b11);

    // 1: lone fetch, then its response one cycle after iMEM_VALID
    tick();
    set_inst(32'h100);
    expect_grant_inst("t1_grant");
    tick();
    inst_req = 1'b0;
    #2;
    check("t1_mem_req", d0_mem_req, 1'b1);
    check("t1_mem_addr", d0_mem_addr, 32'h100);
    check("t1_mem_rw", d0_mem_rw, 1'b1);
    tick();
    check("t1_stage_retired", d0_mem_req, 1'b0);
    send_rsp(1'b0, 64'hA5);
    tick();
    mem_valid = 1'b0;
    check("t1_inst_valid", {d0_inst_valid, d0_data_valid}, 2'b10);
    check("t1_inst_data", d0_inst_data, 64'hA5);
    tick();
    check("t1_strobe_one_cycle", d0_inst_valid, 1'b0);
    check("t1_data_hold", d0_inst_data, 64'hA5);

    // 2: both request every cycle; dut0 alternates D,I,... dut1 always D
    do_reset();
    set_inst(32'h200);
    set_data(1'b0, 32'h240, 32'hDEAD_0001);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        expect_grant_data("t2_rr_data");
        check("t2_rr_inst_locked", d0_inst_lock, 1'b1);
      end else begin
        expect_grant_inst("t2_rr_inst");
        check("t2_rr_data_locked", d0_data_lock, 1'b1);
      end
      check("t2_prio_locks", {d1_inst_lock, d1_data_lock}, 2'b10);
      tick();
    end
    idle_inputs();
    tick();
    for (int k = 0; k < 3; k++) begin
      send_rsp(1'b0, 64'h6000 + 64'(k));
      tick();
    end
    mem_valid = 1'b0;
    tick();
    tick();
    check("t2_no_err", d0_err, 1'b0);

    // 3: memory back-pressure holds the stage; release grants in the same cycle
    do_reset();
    set_data(1'b1, 32'h400, 32'h0);
    expect_grant_data("t3_first");
    tick();
    mem_lock = 1'b1;
    set_inst(32'h500);
    set_data(1'b0, 32'h600, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      #2;
      check("t3_locks_held", {d0_inst_lock, d0_data_lock}, 2'b11);
      check("t3_stage_stable", {d0_mem_req, d0_mem_rw, d0_mem_addr}, {1'b1, 1'b1, 32'h400});
      tick();
    end
    mem_lock = 1'b0;
    expect_grant_inst("t3_release_grant");
    check("t3_release_data_locked", d0_data_lock, 1'b1);
    tick();
    inst_req = 1'b0;
    check("t3_next_addr", d0_mem_addr, 32'h500);
    expect_grant_data("t3_write_after");
    tick();
    data_req = 1'b0;
    tick();
    send_rsp(1'b1, 64'h4444);
    tick();
    send_rsp(1'b0, 64'h5555);
    tick();
    mem_valid = 1'b0;
    tick();

    // 4: outstanding limit; writes still flow; a pop frees a slot next cycle
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_data(1'b1, 32'h700 + 32'(4 * k), 32'h0);
      expect_grant_data("t4_read_fill");
      tick();
    end
    set_data(1'b1, 32'h710, 32'h0);
    #2;
    check("t4_read_full", d0_data_lock, 1'b1);
    tick();
    #2;
    check("t4_read_full_again", d0_data_lock, 1'b1);
    tick();
    set_data(1'b0, 32'h800, 32'h0000_55AA);
    expect_grant_data("t4_write_when_full");
    tick();
    set_data(1'b1, 32'h710, 32'h0);
    send_rsp(1'b1, 64'h11);
    #2;
    check("t4_pop_same_cycle_no_slot", d0_data_lock, 1'b1);
    tick();
    mem_valid = 1'b0;
    expect_grant_data("t4_read_after_pop");
    tick();
    data_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_rsp(1'b1, 64'h12 + 64'(k));
      tick();
    end
    mem_valid = 1'b0;
    tick();
    tick();

    // 5: in-order routing I,D,D,I and a spurious response
    do_reset();
    set_inst(32'h900);
    expect_grant_inst("t5_i0");
    tick();
    inst_req = 1'b0;
    set_data(1'b1, 32'h904, 32'h0);
    expect_grant_data("t5_d1");
    tick();
    set_data(1'b1, 32'h908, 32'h0);
    expect_grant_data("t5_d2");
    tick();
    data_req = 1'b0;
    set_inst(32'h90C);
    expect_grant_inst("t5_i3");
    tick();
    inst_req = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      send_rsp(t5_owner[k], 64'h51 + 64'(k));
      tick();
    end
    mem_valid = 1'b0;
    tick();
    check("t5_err_clear", d0_err, 1'b0);
    mem_valid = 1'b1;
    mem_rdata = 64'hBAD;
    tick();
    mem_valid = 1'b0;
    check("t5_err_set", d0_err, 1'b1);
    check("t5_spurious_no_strobe", {d0_inst_valid, d0_data_valid}, 2'b00);
    tick();
    check("t5_err_sticky", d0_err, 1'b1);

    // 6: reset mid-flight with reads outstanding and a write staged
    do_reset();
    set_data(1'b1, 32'hA00, 32'h0);
    expect_grant_data("t6_d0");
    tick();
    data_req = 1'b0;
    set_inst(32'hA04);
    expect_grant_inst("t6_i1");
    tick();
    inst_req = 1'b0;
    set_data(1'b1, 32'hA08, 32'h0);
    expect_grant_data("t6_d2");
    tick();
    set_data(1'b0, 32'hA0C, 32'h77);
    #2;
    check("t6_write_grant", d0_data_lock, 1'b0);
    tick();
    data_req = 1'b0;
    mem_lock = 1'b1;
    #2;
    check("t6_staged", {d0_mem_req, d0_mem_addr}, {1'b1, 32'hA0C});
    tick();
    rst = 1'b1;
    tick();
    check("t6_rst_outputs",
          {d0_mem_req, d0_mem_rw, d0_mem_addr, d0_mem_data, d0_inst_valid, d0_data_valid, d0_err}, '0);
    rst = 1'b0;
    mem_lock = 1'b0;
    set_inst(32'hB00);
    expect_grant_inst("t6_fresh_fetch");
    tick();
    inst_req = 1'b0;
    check("t6_fresh_addr", d0_mem_addr, 32'hB00);
    tick();
    send_rsp(1'b0, 64'hC0FFEE);
    tick();
    mem_valid = 1'b0;
    check("t6_fresh_rsp_inst", {d0_inst_valid, d0_data_valid}, 2'b10);
    tick();
    mem_valid = 1'b1;
    mem_rdata = 64'hDEAD;
    tick();
    mem_valid = 1'b0;
    check("t6_count_cleared", d0_err, 1'b1);
    tick();
    tick();

    // final report
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
